// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALUContr codes, execute FSM states and width defaults shared by the execute unit and ALU control
package alu_pkg;

  localparam int DEF_DATA_W  = 24;
  localparam int DEF_SHAMT_W = 5;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLT = 4'b0011;
  localparam logic [3:0] ALU_MUL = 4'b0100;
  localparam logic [3:0] ALU_XOR = 4'b0101;
  localparam logic [3:0] ALU_SLL = 4'b0110;
  localparam logic [3:0] ALU_SUB = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - iterative shift-add multiplier datapath with step counter
module alu_mul_seq #(
  parameter int DATA_W = 24,
  parameter int ACC_W  = 24
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Load,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic              Step,
  output logic              Last,
  output logic [ACC_W-1:0]  Product
);

  localparam int CNT_W = $clog2(DATA_W);

  logic [ACC_W-1:0]  mcand_q;
  logic [DATA_W-1:0] mplier_q;
  logic [ACC_W-1:0]  acc_q;
  logic [ACC_W-1:0]  acc_d;
  logic [CNT_W-1:0]  cnt_q;

  // Product includes the current step so the final value is ready on the edge that leaves MUL.
  assign acc_d   = mplier_q[0] ? acc_q + mcand_q : acc_q;
  assign Product = acc_d;
  assign Last    = (cnt_q == '0);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (Load) begin
      mcand_q  <= ACC_W'(A);
      mplier_q <= B;
      acc_q    <= '0;
      cnt_q    <= CNT_W'(DATA_W - 1);
    end else if (Step) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - execute stage: single-cycle ALU ops plus sequential multiply
// Optional ALU_MUL_HI_EN: adds ResultHi, the upper half of the double-width product.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int SHAMT_W = DEF_SHAMT_W
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [3:0]        ALUContr,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic [DATA_W-1:0] Result,
  output logic              Zero,
  output logic              Busy,
`ifdef ALU_MUL_HI_EN
  output logic [DATA_W-1:0] ResultHi,
`endif
  output logic              Done
);

`ifdef ALU_MUL_HI_EN
  localparam int ACC_W = 2 * DATA_W;
`else
  localparam int ACC_W = DATA_W;
`endif

  alu_state_e        state_q;
  logic [DATA_W-1:0] result_q;
  logic              zero_q;
  logic              busy_q;
  logic              done_q;
  logic [DATA_W-1:0] op_result_d;
  logic [SHAMT_W-1:0] shamt;
  logic              mul_load;
  logic              mul_step;
  logic              mul_last;
  logic [ACC_W-1:0]  mul_product;
`ifdef ALU_MUL_HI_EN
  logic [DATA_W-1:0] result_hi_q;
  assign ResultHi = result_hi_q;
`endif

  assign shamt    = B[SHAMT_W-1:0];
  assign mul_load = (state_q == ST_IDLE) && Start && (ALUContr == ALU_MUL);
  assign mul_step = (state_q == ST_MUL);

  // A shift of DATA_W or more shifts every bit out, giving 0 without a separate range check.
  always_comb begin
    op_result_d = '0;
    case (ALUContr)
      ALU_AND: op_result_d = A & B;
      ALU_OR:  op_result_d = A | B;
      ALU_ADD: op_result_d = A + B;
      ALU_SUB: op_result_d = A - B;
      ALU_SLT: op_result_d = DATA_W'($signed(A) < $signed(B));
      ALU_XOR: op_result_d = A ^ B;
      ALU_SLL: op_result_d = A << shamt;
      default: op_result_d = '0;
    endcase
  end

  alu_mul_seq #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mul (
    .Clock   (Clock),
    .Reset   (Reset),
    .Load    (mul_load),
    .A       (A),
    .B       (B),
    .Step    (mul_step),
    .Last    (mul_last),
    .Product (mul_product)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef ALU_MUL_HI_EN
      result_hi_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (Start) begin
            zero_q <= (A == B);
            if (ALUContr == ALU_MUL) begin
              state_q <= ST_MUL;
              busy_q  <= 1'b1;
            end else begin
              result_q <= op_result_d;
              done_q   <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          if (mul_last) begin
            state_q  <= ST_DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= mul_product[DATA_W-1:0];
`ifdef ALU_MUL_HI_EN
            result_hi_q <= mul_product[ACC_W-1:DATA_W];
`endif
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign Result = result_q;
  assign Zero   = zero_q;
  assign Busy   = busy_q;
  assign Done   = done_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - vector table, random reference-model and multi-cycle corner checks for alu_exec_unit
module tb_alu_exec_unit;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic [3:0]  ALUContr = 4'b0;
  logic [23:0] A = '0;
  logic [23:0] B = '0;
  logic [23:0] Result;
  logic        Zero;
  logic        Busy;
  logic        Done;
`ifdef ALU_MUL_HI_EN
  logic [23:0] ResultHi;
`endif

  int total = 0;
  int bad   = 0;

  alu_exec_unit dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Start    (Start),
    .ALUContr (ALUContr),
    .A        (A),
    .B        (B),
    .Result   (Result),
    .Zero     (Zero),
    .Busy     (Busy),
`ifdef ALU_MUL_HI_EN
    .ResultHi (ResultHi),
`endif
    .Done     (Done)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    string       name;
    logic [3:0]  code;
    logic [23:0] a;
    logic [23:0] b;
    logic [23:0] exp_res;
    logic        exp_zero;
    int          exp_lat;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic longint ref_alu(input logic [3:0] c, input longint a, input longint b);
    longint m = 64'hFFFFFF;
    longint sa = (a >= 64'h800000) ? a - 64'h1000000 : a;
    longint sb = (b >= 64'h800000) ? b - 64'h1000000 : b;
    longint sh = b % 32;
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return (a + b) & m;
      4'b1010: return (a - b) & m;
      4'b0011: return (sa < sb) ? 1 : 0;
      4'b0101: return a ^ b;
      4'b0110: return (sh >= 24) ? 0 : ((a << sh) & m);
      4'b0100: return (a * b) & m;
      default: return 0;
    endcase
  endfunction

  task automatic run_op(input logic [3:0] c, input logic [23:0] a, input logic [23:0] b,
                        output logic [23:0] res, output logic z, output int lat, output int bcnt);
    @(negedge Clock);
    ALUContr = c; A = a; B = b; Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    lat = 1;
    bcnt = 0;
    while (!Done && lat < 60) begin
      if (Busy) bcnt++;
      @(negedge Clock);
      lat++;
    end
    chk("done_seen", Done, 1);
    res = Result;
    z = Zero;
  endtask

  vec_t vecs[$];
  logic [3:0] codes[9] = '{4'b0000, 4'b0001, 4'b0010, 4'b1010, 4'b0011,
                           4'b0101, 4'b0110, 4'b0100, 4'b1111};

  initial begin
    logic [23:0] res;
    logic        z;
    int          lat, bcnt, dones;

    vecs.push_back('{"add_wrap",   4'b0010, 24'hFFFFFF, 24'h000001, 24'h000000, 1'b0, 1});
    vecs.push_back('{"sub_neg",    4'b1010, 24'h000005, 24'h000007, 24'hFFFFFE, 1'b0, 1});
    vecs.push_back('{"slt_signed", 4'b0011, 24'hFFFFFF, 24'h000001, 24'h000001, 1'b0, 1});
    vecs.push_back('{"sll_23",     4'b0110, 24'h000001, 24'd23,     24'h800000, 1'b0, 1});
    vecs.push_back('{"sll_24",     4'b0110, 24'h000001, 24'd24,     24'h000000, 1'b0, 1});
    vecs.push_back('{"beq_equal",  4'b0110, 24'h123456, 24'h123456, 24'h800000, 1'b1, 1});
    vecs.push_back('{"bne_differ", 4'b0110, 24'h123456, 24'h123457, 24'h000000, 1'b0, 1});
    vecs.push_back('{"and",        4'b0000, 24'hF0F0F0, 24'h0FF0FF, 24'h00F0F0, 1'b0, 1});
    vecs.push_back('{"or",         4'b0001, 24'hF0F0F0, 24'h0FF0FF, 24'hFFF0FF, 1'b0, 1});
    vecs.push_back('{"xor",        4'b0101, 24'hF0F0F0, 24'h0FF0FF, 24'hFF000F, 1'b0, 1});
    vecs.push_back('{"undef_code", 4'b0111, 24'h000005, 24'h000005, 24'h000000, 1'b1, 1});
    vecs.push_back('{"mul_basic",  4'b0100, 24'h000123, 24'h000456, 24'h04EDC2, 1'b0, 25});

    Reset = 1'b0;
    #12;
    chk("reset_result", Result, 0);
    chk("reset_zero", Zero, 0);
    chk("reset_busy", Busy, 0);
    chk("reset_done", Done, 0);
    @(negedge Clock);
    Reset = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].code, vecs[i].a, vecs[i].b, res, z, lat, bcnt);
      chk({vecs[i].name, "_result"}, res, vecs[i].exp_res);
      chk({vecs[i].name, "_zero"}, z, vecs[i].exp_zero);
      chk({vecs[i].name, "_latency"}, lat, vecs[i].exp_lat);
      chk({vecs[i].name, "_busy_cycles"}, bcnt, (vecs[i].exp_lat == 25) ? 24 : 0);
    end

    repeat (3) @(negedge Clock);
    chk("result_holds", Result, 24'h04EDC2);
    chk("done_low_idle", Done, 0);

`ifdef ALU_MUL_HI_EN
    run_op(4'b0100, 24'hFFFFFF, 24'hFFFFFF, res, z, lat, bcnt);
    chk("mulhi_lo", res, 24'h000001);
    chk("mulhi_hi", ResultHi, 24'hFFFFFE);
    chk("mulhi_zero", z, 1);
`endif

    for (int i = 0; i < 40; i++) begin
      logic [3:0]  c;
      logic [23:0] a, b;
      c = codes[$urandom_range(0, 8)];
      a = 24'($urandom);
      b = (i % 4 == 0) ? 24'($urandom_range(0, 31)) : ((i % 7 == 0) ? a : 24'($urandom));
      run_op(c, a, b, res, z, lat, bcnt);
      chk($sformatf("rand%0d_c%0h_result", i, c), res, ref_alu(c, a, b));
      chk($sformatf("rand%0d_zero", i), z, (a == b) ? 1 : 0);
      chk($sformatf("rand%0d_latency", i), lat, (c == 4'b0100) ? 25 : 1);
    end

    // Start with ADD while multiplying must be ignored
    @(negedge Clock);
    ALUContr = 4'b0100; A = 24'h000123; B = 24'h000456; Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    repeat (4) @(negedge Clock);
    ALUContr = 4'b0010; A = 24'h000001; B = 24'h000002; Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      if (Done) begin
        dones++;
        res = Result;
        chk("busy_start_no_overlap", Busy, 0);
      end
      @(negedge Clock);
    end
    chk("busy_start_done_count", dones, 1);
    chk("busy_start_result", res, 24'h04EDC2);

    // Reset at multiply cycle 10
    @(negedge Clock);
    ALUContr = 4'b0100; A = 24'h000321; B = 24'h000654; Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    repeat (9) @(negedge Clock);
    chk("mid_reset_busy_before", Busy, 1);
    Reset = 1'b0;
    #1;
    chk("mid_reset_result", Result, 0);
    chk("mid_reset_zero", Zero, 0);
    chk("mid_reset_busy", Busy, 0);
    chk("mid_reset_done", Done, 0);
    @(negedge Clock);
    Reset = 1'b1;
    dones = 0;
    for (int k = 0; k < 30; k++) begin
      if (Done || Busy) dones++;
      @(negedge Clock);
    end
    chk("mid_reset_no_done", dones, 0);
    run_op(4'b0100, 24'd3, 24'd4, res, z, lat, bcnt);
    chk("after_reset_mul", res, 12);
    chk("after_reset_mul_latency", lat, 25);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
